// File: rtl/chip8_pkg.sv
// CHIP-8 / SUPER-CHIP operation codes and the opcode lookup, shared by the
// decoder and the execute stage.
package chip8_pkg;

    localparam int OP_BITS = 6;
    typedef logic [OP_BITS-1:0] op_t;

    localparam op_t OP_NONE     = 6'd0;
    localparam op_t OP_ILLEGAL  = 6'd1;
    localparam op_t OP_CLS      = 6'd2;
    localparam op_t OP_RET      = 6'd3;
    localparam op_t OP_SYS      = 6'd4;
    localparam op_t OP_JP       = 6'd5;
    localparam op_t OP_CALL     = 6'd6;
    localparam op_t OP_SE_VB    = 6'd7;
    localparam op_t OP_SNE_VB   = 6'd8;
    localparam op_t OP_SE_VV    = 6'd9;
    localparam op_t OP_LD_VB    = 6'd10;
    localparam op_t OP_ADD_VB   = 6'd11;
    localparam op_t OP_LD_VV    = 6'd12;
    localparam op_t OP_OR_VV    = 6'd13;
    localparam op_t OP_AND_VV   = 6'd14;
    localparam op_t OP_XOR_VV   = 6'd15;
    localparam op_t OP_ADD_VV   = 6'd16;
    localparam op_t OP_SUB_VV   = 6'd17;
    localparam op_t OP_SHR_VV   = 6'd18;
    localparam op_t OP_SUBN_VV  = 6'd19;
    localparam op_t OP_SHL_VV   = 6'd20;
    localparam op_t OP_SNE_VV   = 6'd21;
    localparam op_t OP_LD_I     = 6'd22;
    localparam op_t OP_JP_V0    = 6'd23;
    localparam op_t OP_RND      = 6'd24;
    localparam op_t OP_DRW      = 6'd25;
    localparam op_t OP_SKP      = 6'd26;
    localparam op_t OP_SKNP     = 6'd27;
    localparam op_t OP_LD_VDT   = 6'd28;
    localparam op_t OP_LD_K     = 6'd29;
    localparam op_t OP_LD_DT    = 6'd30;
    localparam op_t OP_LD_ST    = 6'd31;
    localparam op_t OP_ADD_I    = 6'd32;
    localparam op_t OP_LD_F     = 6'd33;
    localparam op_t OP_BCD      = 6'd34;
    localparam op_t OP_ST_REGS  = 6'd35;
    localparam op_t OP_LD_REGS  = 6'd36;
    localparam op_t OP_SCD      = 6'd37;
    localparam op_t OP_SCR      = 6'd38;
    localparam op_t OP_SCL      = 6'd39;
    localparam op_t OP_EXIT     = 6'd40;
    localparam op_t OP_LOW      = 6'd41;
    localparam op_t OP_HIGH     = 6'd42;
    localparam op_t OP_LD_HF    = 6'd43;
    localparam op_t OP_ST_RPL   = 6'd44;
    localparam op_t OP_LD_RPL   = 6'd45;

    function automatic op_t chip8_decode_op(input logic [15:0] instr, input logic schip_en);
        op_t        op;
        logic [7:0] kk;
        logic [3:0] n;
        kk = instr[7:0];
        n  = instr[3:0];
        op = OP_ILLEGAL;
        case (instr[15:12])
            4'h0: begin
                // Without SUPER-CHIP every unrecognised 0nnn is a machine-code call.
                op = OP_SYS;
                if (instr == 16'h00E0)
                    op = OP_CLS;
                else if (instr == 16'h00EE)
                    op = OP_RET;
                else if (schip_en && instr[11:4] == 8'h0C)
                    op = OP_SCD;
                else if (schip_en && instr[11:8] == 4'h0) begin
                    case (kk)
                        8'hFB:   op = OP_SCR;
                        8'hFC:   op = OP_SCL;
                        8'hFD:   op = OP_EXIT;
                        8'hFE:   op = OP_LOW;
                        8'hFF:   op = OP_HIGH;
                        default: op = OP_SYS;
                    endcase
                end
            end
            4'h1: op = OP_JP;
            4'h2: op = OP_CALL;
            4'h3: op = OP_SE_VB;
            4'h4: op = OP_SNE_VB;
            4'h5: op = (n == 4'h0) ? OP_SE_VV : OP_ILLEGAL;
            4'h6: op = OP_LD_VB;
            4'h7: op = OP_ADD_VB;
            4'h8: begin
                case (n)
                    4'h0:    op = OP_LD_VV;
                    4'h1:    op = OP_OR_VV;
                    4'h2:    op = OP_AND_VV;
                    4'h3:    op = OP_XOR_VV;
                    4'h4:    op = OP_ADD_VV;
                    4'h5:    op = OP_SUB_VV;
                    4'h6:    op = OP_SHR_VV;
                    4'h7:    op = OP_SUBN_VV;
                    4'hE:    op = OP_SHL_VV;
                    default: op = OP_ILLEGAL;
                endcase
            end
            4'h9: op = (n == 4'h0) ? OP_SNE_VV : OP_ILLEGAL;
            4'hA: op = OP_LD_I;
            4'hB: op = OP_JP_V0;
            4'hC: op = OP_RND;
            4'hD: op = OP_DRW;
            4'hE: begin
                case (kk)
                    8'h9E:   op = OP_SKP;
                    8'hA1:   op = OP_SKNP;
                    default: op = OP_ILLEGAL;
                endcase
            end
            4'hF: begin
                case (kk)
                    8'h07:   op = OP_LD_VDT;
                    8'h0A:   op = OP_LD_K;
                    8'h15:   op = OP_LD_DT;
                    8'h18:   op = OP_LD_ST;
                    8'h1E:   op = OP_ADD_I;
                    8'h29:   op = OP_LD_F;
                    8'h33:   op = OP_BCD;
                    8'h55:   op = OP_ST_REGS;
                    8'h65:   op = OP_LD_REGS;
                    8'h30:   op = schip_en ? OP_LD_HF  : OP_ILLEGAL;
                    8'h75:   op = schip_en ? OP_ST_RPL : OP_ILLEGAL;
                    8'h85:   op = schip_en ? OP_LD_RPL : OP_ILLEGAL;
                    default: op = OP_ILLEGAL;
                endcase
            end
        endcase
        return op;
    endfunction

endpackage

// File: rtl/chip8_skid_buf.sv
// Two-entry valid/ready register slice; upstream ready depends only on the
// registered skid state, never on downstream ready.
module chip8_skid_buf #(
    parameter int DATA_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_flush,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data
);

    logic              r_outValid;
    logic              r_skidValid;
    logic [DATA_W-1:0] r_outData;
    logic [DATA_W-1:0] r_skidData;
    logic              w_inXfer;
    logic              w_outDrain;

    assign o_ready    = ~r_skidValid & ~i_rst;
    assign w_inXfer   = i_valid & o_ready;
    assign w_outDrain = ~r_outValid | i_ready;
    assign o_valid    = r_outValid;
    assign o_data     = r_outData;

    // The skid entry always drains first so ordering is preserved.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_outValid  <= 1'b0;
            r_skidValid <= 1'b0;
            r_outData   <= '0;
            r_skidData  <= '0;
        end else if (i_flush) begin
            r_outValid  <= 1'b0;
            r_skidValid <= 1'b0;
        end else if (w_outDrain) begin
            if (r_skidValid) begin
                r_outData   <= r_skidData;
                r_outValid  <= 1'b1;
                r_skidValid <= 1'b0;
            end else begin
                r_outValid <= w_inXfer;
                if (w_inXfer)
                    r_outData <= i_data;
            end
        end else if (w_inXfer) begin
            r_skidData  <= i_data;
            r_skidValid <= 1'b1;
        end
    end

endmodule

// File: rtl/chip8_decode_pipe.sv
// Pipelined CHIP-8 decoder: opcode lookup ahead of a skid buffer, with the
// operand fields re-derived from the buffered instruction word.
module chip8_decode_pipe
    import chip8_pkg::*;
#(
    parameter int ADDR_W   = 12,
    parameter int SCHIP_EN = 0,
    parameter int OP_W     = 6
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_flush,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [15:0]       i_instruction,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [OP_W-1:0]   o_op,
    output logic [3:0]        o_x,
    output logic [3:0]        o_y,
    output logic [3:0]        o_n,
    output logic [7:0]        o_val,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_illegal,
    output logic [15:0]       o_illegal_count
);

    localparam int DATA_W = OP_BITS + 16;

    op_t               w_decOp;
    op_t               w_bufOp;
    logic [15:0]       w_bufInstr;
    logic [DATA_W-1:0] w_bufData;
    logic              w_inXfer;
    logic [15:0]       r_illegalCount;

    assign w_decOp  = chip8_decode_op(i_instruction, SCHIP_EN != 0);
    assign w_inXfer = i_in_valid & o_in_ready;

    chip8_skid_buf #(
        .DATA_W (DATA_W)
    ) u_skid (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_flush (i_flush),
        .i_valid (i_in_valid),
        .o_ready (o_in_ready),
        .i_data  ({w_decOp, i_instruction}),
        .o_valid (o_out_valid),
        .i_ready (i_out_ready),
        .o_data  (w_bufData)
    );

    assign w_bufOp    = w_bufData[DATA_W-1:16];
    assign w_bufInstr = w_bufData[15:0];

    assign o_op      = OP_W'(w_bufOp);
    assign o_x       = w_bufInstr[11:8];
    assign o_y       = w_bufInstr[7:4];
    assign o_n       = w_bufInstr[3:0];
    assign o_val     = w_bufInstr[7:0];
    assign o_addr    = ADDR_W'(w_bufInstr[11:0]);
    assign o_illegal = (w_bufOp == OP_ILLEGAL);
    assign o_illegal_count = r_illegalCount;

    // Inputs accepted during a flush are discarded, so they are not counted.
    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_illegalCount <= '0;
        else if (w_inXfer && !i_flush && w_decOp == OP_ILLEGAL && r_illegalCount != 16'hFFFF)
            r_illegalCount <= r_illegalCount + 16'd1;
    end

endmodule

// File: tb/tb_chip8_decode_pipe.sv
// Directed bench for chip8_decode_pipe: a base instance and a SUPER-CHIP
// instance with a 16-bit address share the same stimulus.
module tb_chip8_decode_pipe;
    import chip8_pkg::*;

    logic        clk = 1'b0;
    logic        rst, flush, inValid, outReady;
    logic [15:0] instruction;

    logic        inReady0, outValid0, illegal0;
    logic [5:0]  op0;
    logic [3:0]  x0, y0, n0;
    logic [7:0]  val0;
    logic [11:0] addr0;
    logic [15:0] cnt0;

    logic        inReady1, outValid1, illegal1;
    logic [5:0]  op1;
    logic [3:0]  x1, y1, n1;
    logic [7:0]  val1;
    logic [15:0] addr1;
    logic [15:0] cnt1;

    int numVectors = 0;
    int numMiscompares = 0;
    int expCnt0 = 0;
    int expCnt1 = 0;

    typedef struct {
        logic [15:0] instr;
        op_t         op0;
        op_t         op1;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    chip8_decode_pipe #(.ADDR_W(12), .SCHIP_EN(0), .OP_W(6)) dut0 (
        .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_in_valid(inValid),
        .o_in_ready(inReady0), .i_instruction(instruction), .o_out_valid(outValid0),
        .i_out_ready(outReady), .o_op(op0), .o_x(x0), .o_y(y0), .o_n(n0),
        .o_val(val0), .o_addr(addr0), .o_illegal(illegal0), .o_illegal_count(cnt0)
    );

    chip8_decode_pipe #(.ADDR_W(16), .SCHIP_EN(1), .OP_W(6)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_in_valid(inValid),
        .o_in_ready(inReady1), .i_instruction(instruction), .o_out_valid(outValid1),
        .i_out_ready(outReady), .o_op(op1), .o_x(x1), .o_y(y1), .o_n(n1),
        .o_val(val1), .o_addr(addr1), .o_illegal(illegal1), .o_illegal_count(cnt1)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        numVectors++;
        if (act !== exp) begin
            numMiscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [15:0] ins, input logic ordy, input logic fl);
        inValid     = v;
        instruction = ins;
        outReady    = ordy;
        flush       = fl;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkFields(input string tag, input logic [15:0] ins, input op_t e0, input op_t e1);
        checkOutput({tag, " valid0"}, 32'(outValid0), 32'd1);
        checkOutput({tag, " valid1"}, 32'(outValid1), 32'd1);
        checkOutput({tag, " op0"}, 32'(op0), 32'(e0));
        checkOutput({tag, " op1"}, 32'(op1), 32'(e1));
        checkOutput({tag, " x"}, 32'(x0), 32'(ins[11:8]));
        checkOutput({tag, " y"}, 32'(y0), 32'(ins[7:4]));
        checkOutput({tag, " n"}, 32'(n0), 32'(ins[3:0]));
        checkOutput({tag, " val"}, 32'(val0), 32'(ins[7:0]));
        checkOutput({tag, " fields1"}, {16'(x1), 8'(val1), y1, n1}, {16'(ins[11:8]), ins[7:0], ins[7:4], ins[3:0]});
        checkOutput({tag, " addr0"}, 32'(addr0), 32'(ins[11:0]));
        checkOutput({tag, " addr1"}, 32'(addr1), 32'(ins[11:0]));
        checkOutput({tag, " illegal0"}, 32'(illegal0), 32'(e0 == OP_ILLEGAL));
        checkOutput({tag, " illegal1"}, 32'(illegal1), 32'(e1 == OP_ILLEGAL));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs.push_back('{16'h00E0, OP_CLS,     OP_CLS});
        vecs.push_back('{16'h1234, OP_JP,      OP_JP});
        vecs.push_back('{16'h8AB4, OP_ADD_VV,  OP_ADD_VV});
        vecs.push_back('{16'hD125, OP_DRW,     OP_DRW});
        vecs.push_back('{16'h00EE, OP_RET,     OP_RET});
        vecs.push_back('{16'h0123, OP_SYS,     OP_SYS});
        vecs.push_back('{16'h2456, OP_CALL,    OP_CALL});
        vecs.push_back('{16'h3A12, OP_SE_VB,   OP_SE_VB});
        vecs.push_back('{16'h4B34, OP_SNE_VB,  OP_SNE_VB});
        vecs.push_back('{16'h5120, OP_SE_VV,   OP_SE_VV});
        vecs.push_back('{16'h5121, OP_ILLEGAL, OP_ILLEGAL});
        vecs.push_back('{16'h6A55, OP_LD_VB,   OP_LD_VB});
        vecs.push_back('{16'h7B01, OP_ADD_VB,  OP_ADD_VB});
        vecs.push_back('{16'h8AB0, OP_LD_VV,   OP_LD_VV});
        vecs.push_back('{16'h8AB3, OP_XOR_VV,  OP_XOR_VV});
        vecs.push_back('{16'h8AB7, OP_SUBN_VV, OP_SUBN_VV});
        vecs.push_back('{16'h8ABE, OP_SHL_VV,  OP_SHL_VV});
        vecs.push_back('{16'h8AB9, OP_ILLEGAL, OP_ILLEGAL});
        vecs.push_back('{16'h8ABF, OP_ILLEGAL, OP_ILLEGAL});
        vecs.push_back('{16'h9120, OP_SNE_VV,  OP_SNE_VV});
        vecs.push_back('{16'h9125, OP_ILLEGAL, OP_ILLEGAL});
        vecs.push_back('{16'hA123, OP_LD_I,    OP_LD_I});
        vecs.push_back('{16'hB456, OP_JP_V0,   OP_JP_V0});
        vecs.push_back('{16'hC1FF, OP_RND,     OP_RND});
        vecs.push_back('{16'hE19E, OP_SKP,     OP_SKP});
        vecs.push_back('{16'hE1A1, OP_SKNP,    OP_SKNP});
        vecs.push_back('{16'hE1A2, OP_ILLEGAL, OP_ILLEGAL});
        vecs.push_back('{16'hF107, OP_LD_VDT,  OP_LD_VDT});
        vecs.push_back('{16'hF10A, OP_LD_K,    OP_LD_K});
        vecs.push_back('{16'hF115, OP_LD_DT,   OP_LD_DT});
        vecs.push_back('{16'hF118, OP_LD_ST,   OP_LD_ST});
        vecs.push_back('{16'hF11E, OP_ADD_I,   OP_ADD_I});
        vecs.push_back('{16'hF129, OP_LD_F,    OP_LD_F});
        vecs.push_back('{16'hF133, OP_BCD,     OP_BCD});
        vecs.push_back('{16'hF155, OP_ST_REGS, OP_ST_REGS});
        vecs.push_back('{16'hF165, OP_LD_REGS, OP_LD_REGS});
        vecs.push_back('{16'hF0FF, OP_ILLEGAL, OP_ILLEGAL});
        vecs.push_back('{16'h00FF, OP_SYS,     OP_HIGH});
        vecs.push_back('{16'h00C3, OP_SYS,     OP_SCD});
        vecs.push_back('{16'h00FB, OP_SYS,     OP_SCR});
        vecs.push_back('{16'h00FC, OP_SYS,     OP_SCL});
        vecs.push_back('{16'h00FD, OP_SYS,     OP_EXIT});
        vecs.push_back('{16'h00FE, OP_SYS,     OP_LOW});
        vecs.push_back('{16'hF330, OP_ILLEGAL, OP_LD_HF});
        vecs.push_back('{16'hF375, OP_ILLEGAL, OP_ST_RPL});
        vecs.push_back('{16'hF385, OP_ILLEGAL, OP_LD_RPL});
        vecs.push_back('{16'h2FFF, OP_CALL,    OP_CALL});

        // Reset state, including in_ready held low during reset.
        rst = 1'b1;
        applyStimulus(1'b1, 16'h1234, 1'b1, 1'b0);
        step();
        step();
        checkOutput("rst in_ready0", 32'(inReady0), 32'd0);
        checkOutput("rst in_ready1", 32'(inReady1), 32'd0);
        checkOutput("rst out_valid", 32'(outValid0), 32'd0);
        checkOutput("rst op", 32'(op0), 32'(OP_NONE));
        checkOutput("rst addr", 32'(addr1), 32'd0);
        checkOutput("rst val", 32'(val0), 32'd0);
        checkOutput("rst illegal", 32'(illegal0), 32'd0);
        checkOutput("rst count", 32'(cnt0), 32'd0);
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
        rst = 1'b0;
        #1;
        checkOutput("post-rst in_ready", 32'(inReady0), 32'd1);

        // Full-throughput stream, one decode per cycle with one cycle latency.
        foreach (vecs[i]) begin
            applyStimulus(1'b1, vecs[i].instr, 1'b1, 1'b0);
            #1;
            checkOutput($sformatf("vec%0d in_ready", i), 32'(inReady0), 32'd1);
            step();
            checkFields($sformatf("vec%0d %h", i, vecs[i].instr), vecs[i].instr, vecs[i].op0, vecs[i].op1);
            if (vecs[i].op0 == OP_ILLEGAL) expCnt0++;
            if (vecs[i].op1 == OP_ILLEGAL) expCnt1++;
        end
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
        checkOutput("table count0", 32'(cnt0), 32'(expCnt0));
        checkOutput("table count1", 32'(cnt1), 32'(expCnt1));
        step();
        checkOutput("idle out_valid", 32'(outValid0), 32'd0);

        // Back-pressure: two accepted, third held off, outputs stable.
        applyStimulus(1'b1, 16'hA111, 1'b0, 1'b0);
        step();
        checkOutput("stall1 addr", 32'(addr0), 32'h111);
        applyStimulus(1'b1, 16'hA222, 1'b0, 1'b0);
        #1;
        checkOutput("stall2 in_ready", 32'(inReady0), 32'd1);
        step();
        checkOutput("stall2 addr", 32'(addr0), 32'h111);
        applyStimulus(1'b1, 16'hA333, 1'b0, 1'b0);
        #1;
        checkOutput("stall3 in_ready", 32'(inReady0), 32'd0);
        step();
        checkOutput("stall3 addr", 32'(addr0), 32'h111);
        checkOutput("stall3 op", 32'(op0), 32'(OP_LD_I));
        checkOutput("stall3 valid", 32'(outValid0), 32'd1);
        step();
        checkOutput("stall4 addr", 32'(addr1), 32'h111);
        applyStimulus(1'b1, 16'hA333, 1'b1, 1'b0);
        step();
        checkOutput("drain1 addr", 32'(addr0), 32'h222);
        checkOutput("drain1 valid", 32'(outValid0), 32'd1);
        step();
        checkOutput("drain2 addr", 32'(addr0), 32'h333);
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
        step();
        checkOutput("drain3 valid", 32'(outValid0), 32'd0);

        // Reset asserted while both entries hold illegal opcodes.
        applyStimulus(1'b1, 16'h5121, 1'b0, 1'b0);
        step();
        applyStimulus(1'b1, 16'hF0FF, 1'b0, 1'b0);
        step();
        expCnt0 += 2;
        checkOutput("prerst illegal", 32'(illegal0), 32'd1);
        checkOutput("prerst count", 32'(cnt0), 32'(expCnt0));
        checkOutput("prerst in_ready", 32'(inReady0), 32'd0);
        rst = 1'b1;
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
        step();
        checkOutput("midrst valid", 32'(outValid0), 32'd0);
        checkOutput("midrst fields", {op0, x0, y0, n0, val0, illegal0}, 32'd0);
        checkOutput("midrst addr", 32'(addr0), 32'd0);
        checkOutput("midrst count0", 32'(cnt0), 32'd0);
        checkOutput("midrst count1", 32'(cnt1), 32'd0);
        rst = 1'b0;
        expCnt0 = 0;
        expCnt1 = 0;

        // Illegal stream and counter persistence across flush.
        foreach (vecs[i]) begin
            if (vecs[i].instr == 16'h5121 || vecs[i].instr == 16'h8AB9 || vecs[i].instr == 16'hF0FF) begin
                applyStimulus(1'b1, vecs[i].instr, 1'b1, 1'b0);
                step();
                checkFields($sformatf("ill %h", vecs[i].instr), vecs[i].instr, OP_ILLEGAL, OP_ILLEGAL);
                expCnt0++;
                expCnt1++;
            end
        end
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
        checkOutput("ill count0", 32'(cnt0), 32'(expCnt0));
        checkOutput("ill count1", 32'(cnt1), 32'(3));
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b1);
        step();
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
        checkOutput("flush valid", 32'(outValid0), 32'd0);
        checkOutput("flush count", 32'(cnt0), 32'd3);
        checkOutput("flush in_ready", 32'(inReady0), 32'd1);

        // Flush with the skid entry full.
        applyStimulus(1'b1, 16'h1111, 1'b0, 1'b0);
        step();
        applyStimulus(1'b1, 16'h2222, 1'b0, 1'b0);
        step();
        checkOutput("skidfull in_ready", 32'(inReady0), 32'd0);
        applyStimulus(1'b1, 16'h5121, 1'b0, 1'b1);
        step();
        checkOutput("flushA valid0", 32'(outValid0), 32'd0);
        checkOutput("flushA valid1", 32'(outValid1), 32'd0);
        checkOutput("flushA in_ready", 32'(inReady0), 32'd1);
        checkOutput("flushA count", 32'(cnt0), 32'd3);

        // Flush coinciding with an accepted illegal input: dropped, uncounted.
        applyStimulus(1'b1, 16'hA111, 1'b0, 1'b0);
        step();
        applyStimulus(1'b1, 16'h8ABF, 1'b0, 1'b1);
        #1;
        checkOutput("flushB in_ready", 32'(inReady0), 32'd1);
        step();
        checkOutput("flushB valid", 32'(outValid0), 32'd0);
        checkOutput("flushB count0", 32'(cnt0), 32'd3);
        checkOutput("flushB count1", 32'(cnt1), 32'd3);
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
        step();
        checkOutput("flushB after1", 32'(outValid0), 32'd0);
        step();
        checkOutput("flushB after2", 32'(outValid1), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", numVectors, numMiscompares);
        $finish;
    end

endmodule
